// File: rtl/simple_sweep.sv
// simple_sweep: exhaustive sequencer for a 4-input / 2-output combinational unit.
// Walks all 16 input vectors A..D in order, holds each for SETTLE cycles,
// captures {F,E} into a 32-bit truth table and compares it against a reference.
//
// Interface contract (no valid/ready handshake here): i_start is a level
// sampled only in IDLE; o_done is a one-cycle pulse; o_table, o_mismatch and
// o_fail_index are stable from o_done until the next accepted start or reset.
module simple_sweep #(
    parameter int SETTLE = 2  // legal range 1..255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_expected,
    output logic        o_stim_a,
    output logic        o_stim_b,
    output logic        o_stim_c,
    output logic        o_stim_d,
    input  logic        i_resp_e,
    input  logic        i_resp_f,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_table,
    output logic        o_mismatch,
    output logic [3:0]  o_fail_index,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Terminal value of the settle counter; the counter runs 0..SETTLE-1.
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [7:0]  r_count;
    logic [3:0]  r_stim;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_table;
    logic        r_mismatch;
    logic [3:0]  r_fail_index;

    logic [4:0]  w_bit_lo;
    logic [1:0]  w_resp_pair;
    logic [1:0]  w_exp_pair;
    logic        w_differs;
    logic [3:0]  w_idx_next;

    // Slice selection for the current vector and the response comparison.
    always_comb begin
        w_bit_lo    = {r_idx, 1'b0};
        w_resp_pair = {i_resp_f, i_resp_e};
        w_exp_pair  = i_expected[w_bit_lo +: 2];
        w_differs   = (w_resp_pair != w_exp_pair);
        w_idx_next  = r_idx + 4'd1;
    end

    // Sweep FSM with all outputs registered; reset abandons any sweep in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= 4'd0;
            r_count      <= 8'd0;
            r_stim       <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_table      <= 32'd0;
            r_mismatch   <= 1'b0;
            r_fail_index <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    // Results from the previous sweep stay visible until a new
                    // sweep is actually accepted, so clearing happens here.
                    if (i_start) begin
                        r_state      <= ST_DRIVE;
                        r_idx        <= 4'd0;
                        r_count      <= 8'd0;
                        r_stim       <= 4'd0;
                        r_busy       <= 1'b1;
                        r_table      <= 32'd0;
                        r_mismatch   <= 1'b0;
                        r_fail_index <= 4'd0;
                    end
                end

                ST_DRIVE: begin
                    // Stimulus is already on the pins; just let it settle.
                    if (r_count == SETTLE_M1) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end

                ST_SAMPLE: begin
                    r_table[w_bit_lo +: 2] <= w_resp_pair;
                    if (w_differs) begin
                        // First mismatch wins; later ones only keep the flag set.
                        if (!r_mismatch) begin
                            r_fail_index <= r_idx;
                        end
                        r_mismatch <= 1'b1;
                    end
                    if (r_idx == 4'd15) begin
                        r_state <= ST_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_stim  <= 4'd0;
                    end else begin
                        r_state <= ST_DRIVE;
                        r_idx   <= w_idx_next;
                        r_stim  <= w_idx_next;
                        r_count <= 8'd0;
                    end
                end

                ST_FINISH: begin
                    // One-cycle completion pulse, then back to idle.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_stim  <= 4'd0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stimulus mapping: A is the index MSB, D the LSB.
    assign o_stim_a     = r_stim[3];
    assign o_stim_b     = r_stim[2];
    assign o_stim_c     = r_stim[1];
    assign o_stim_d     = r_stim[0];
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_table      = r_table;
    assign o_mismatch   = r_mismatch;
    assign o_fail_index = r_fail_index;
    assign o_state      = r_state;

endmodule

// File: tb/tb_simple_sweep.sv
// Bench for simple_sweep: two instances (SETTLE=2 and SETTLE=1) each wired to a
// behavioural unit E=A&B, F=C|D. Expected sweep results go into exp_q when a
// start is driven and are popped when o_done is seen.
module tb_simple_sweep;

  logic clk;
  logic rst;

  logic        start2, start1;
  logic [31:0] exp2, exp1;
  logic        sa2, sb2, sc2, sd2, sa1, sb1, sc1, sd1;
  logic        re2, rf2, re1, rf1;
  logic        busy2, busy1, done2, done1;
  logic [31:0] tbl2, tbl1;
  logic        mm2, mm1;
  logic [3:0]  fi2, fi1;
  logic [1:0]  st2, st1;

  int tests_run;
  int tests_failed;
  logic [36:0] exp_q[$];

  // which instance the sweep tasks observe: 0 -> SETTLE=2, 1 -> SETTLE=1
  logic        sel;
  logic        o_busy, o_done, o_mm;
  logic [3:0]  o_stim, o_fi;
  logic [31:0] o_tbl;
  logic [1:0]  o_st;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural combinational units under test
  assign re2 = sa2 & sb2;
  assign rf2 = sc2 | sd2;
  assign re1 = sa1 & sb1;
  assign rf1 = sc1 | sd1;

  always_comb begin
    if (sel) begin
      o_busy = busy1; o_done = done1; o_mm = mm1; o_fi = fi1;
      o_tbl = tbl1; o_st = st1; o_stim = {sa1, sb1, sc1, sd1};
    end else begin
      o_busy = busy2; o_done = done2; o_mm = mm2; o_fi = fi2;
      o_tbl = tbl2; o_st = st2; o_stim = {sa2, sb2, sc2, sd2};
    end
  end

  simple_sweep #(.SETTLE(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_expected(exp2),
    .o_stim_a(sa2), .o_stim_b(sb2), .o_stim_c(sc2), .o_stim_d(sd2),
    .i_resp_e(re2), .i_resp_f(rf2), .o_busy(busy2), .o_done(done2),
    .o_table(tbl2), .o_mismatch(mm2), .o_fail_index(fi2), .o_state(st2)
  );

  simple_sweep #(.SETTLE(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_expected(exp1),
    .o_stim_a(sa1), .o_stim_b(sb1), .o_stim_c(sc1), .o_stim_d(sd1),
    .i_resp_e(re1), .i_resp_f(rf1), .o_busy(busy1), .o_done(done1),
    .o_table(tbl1), .o_mismatch(mm1), .o_fail_index(fi1), .o_state(st1)
  );

  // reference truth table for E=A&B, F=C|D with A=idx[3] .. D=idx[0]
  function automatic logic [31:0] model_table();
    logic [31:0] t;
    logic [3:0]  v;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      t[2*i]   = v[3] & v[2];
      t[2*i+1] = v[1] | v[0];
    end
    return t;
  endfunction

  // {table, mismatch, fail_index} a correct sweep must report
  function automatic logic [36:0] predict(input logic [31:0] ref_tbl);
    logic [31:0] t;
    logic        m;
    logic [3:0]  f;
    t = model_table();
    m = 1'b0;
    f = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (t[2*i +: 2] != ref_tbl[2*i +: 2] && !m) begin
        m = 1'b1;
        f = 4'(i);
      end
    end
    return {t, m, f};
  endfunction

  // driver tasks
  task automatic drive_start(input logic v);
    if (sel) start1 = v; else start2 = v;
  endtask

  task automatic drive_expected(input logic [31:0] v);
    if (sel) exp1 = v; else exp2 = v;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one sweep starting at a negedge; checks busy/done/stim per cycle,
  // pops the scoreboard on done and checks the held results one cycle later.
  task automatic run_sweep(input logic [31:0] ref_tbl, input int settle,
                           input bit hold_start, input string name);
    int last;
    logic [36:0] exp_res;
    logic [3:0]  exp_stim;
    last = 16 * (settle + 1) + 1;
    drive_expected(ref_tbl);
    drive_start(1'b1);
    exp_q.push_back(predict(ref_tbl));
    @(posedge clk);
    #1;
    if (!hold_start) drive_start(1'b0);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      exp_stim = (c < last) ? 4'((c - 1) / (settle + 1)) : 4'd0;
      tests_run++;
      if (o_busy !== (c < last)) begin
        tests_failed++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, c, o_busy, c < last);
      end
      tests_run++;
      if (o_done !== (c == last)) begin
        tests_failed++;
        $display("FAIL %s done cycle %0d: got %b want %b", name, c, o_done, c == last);
      end
      tests_run++;
      if (o_stim !== exp_stim) begin
        tests_failed++;
        $display("FAIL %s stim cycle %0d: got %h want %h", name, c, o_stim, exp_stim);
      end
    end
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s scoreboard empty at done", name);
    end else begin
      exp_res = exp_q.pop_front();
      tests_run++;
      if ({o_tbl, o_mm, o_fi} !== exp_res) begin
        tests_failed++;
        $display("FAIL %s result: got table=%h mm=%b fi=%0d want table=%h mm=%b fi=%0d",
                 name, o_tbl, o_mm, o_fi, exp_res[36:5], exp_res[4], exp_res[3:0]);
      end
    end
    // cycle after done: idle, results held
    @(negedge clk);
    tests_run++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_st !== 2'd0 ||
        {o_tbl, o_mm, o_fi} !== exp_res) begin
      tests_failed++;
      $display("FAIL %s hold after done: busy=%b done=%b state=%0d table=%h mm=%b fi=%0d",
               name, o_busy, o_done, o_st, o_tbl, o_mm, o_fi);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy2, done2, tbl2, mm2, fi2, st2, sa2, sb2, sc2, sd2} !== '0 ||
        {busy1, done1, tbl1, mm1, fi1, st1, sa1, sb1, sc1, sd1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: dut2 busy=%b done=%b table=%h mm=%b fi=%0d st=%0d dut1 busy=%b table=%h st=%0d want all 0",
               busy2, done2, tbl2, mm2, fi2, st2, busy1, tbl1, st1);
    end
    rst = 1'b0;
  endtask

  task automatic test_pass();
    sel = 1'b0;
    tests_run++;
    if (model_table() !== 32'hFDA8A8A8) begin
      tests_failed++;
      $display("FAIL model_table: got %h want fda8a8a8", model_table());
    end
    run_sweep(32'hFDA8A8A8, 2, 1'b0, "pass_s2");
  endtask

  task automatic test_mismatch();
    sel = 1'b0;
    run_sweep(32'hFDA8A8A9, 2, 1'b0, "mismatch_v0");
    run_sweep(32'hF5A8A888, 2, 1'b0, "mismatch_first_wins");
    // results must be cleared by the next accepted start
    run_sweep(32'hFDA8A8A8, 2, 1'b0, "clear_on_start");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_sweep(32'hFDA8A8A8, 2, 1'b1, "hold_start");
    // start still high: a new sweep was accepted at cycle 50
    @(negedge clk);
    tests_run++;
    if (o_busy !== 1'b1 || o_st !== 2'd1 || o_stim !== 4'd0) begin
      tests_failed++;
      $display("FAIL hold_start restart cycle 51: busy=%b state=%0d stim=%h want 1 1 0",
               o_busy, o_st, o_stim);
    end
    drive_start(1'b0);
    apply_reset();
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    drive_expected(32'hFDA8A8A8);
    drive_start(1'b1);
    @(posedge clk);
    #1;
    drive_start(1'b0);
    for (int c = 1; c <= 22; c++) @(negedge clk);
    tests_run++;
    if (o_stim !== 4'd7 || o_tbl === 32'd0) begin
      tests_failed++;
      $display("FAIL mid_reset pre: stim=%h table=%h want stim 7 and partial table", o_stim, o_tbl);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy2, done2, tbl2, mm2, fi2, st2, sa2, sb2, sc2, sd2} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset: busy=%b done=%b table=%h mm=%b fi=%0d st=%0d stim=%h want all 0",
               busy2, done2, tbl2, mm2, fi2, st2, {sa2, sb2, sc2, sd2});
    end
    rst = 1'b0;
    run_sweep(32'hFDA8A8A8, 2, 1'b0, "after_mid_reset");
  endtask

  task automatic test_settle1();
    sel = 1'b1;
    run_sweep(32'hFDA8A8A8, 1, 1'b0, "pass_s1");
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start2 = 1'b0; start1 = 1'b0;
    exp2 = 32'd0;  exp1 = 32'd0;
    sel = 1'b0;
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_pass();
    test_mismatch();
    test_back_to_back();
    test_mid_reset();
    test_settle1();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
